// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester byte streams plus the Wishbone write port to the UART
interface uart_tx_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [N_REQ-1:0]      i_VALID;
    logic [8*N_REQ-1:0]    i_BYTE;
    logic [N_REQ-1:0]      i_LAST;
    logic [N_REQ-1:0]      o_READY;
    logic [ADDR_WIDTH-1:0] o_ADDR;
    logic [DATA_WIDTH-1:0] o_DATA;
    logic                  o_WE;
    logic [3:0]            o_SEL;
    logic                  o_STB;
    logic                  o_CYC;
    logic                  i_ACK;
    logic                  i_TX_FULL;
    logic [2:0]            o_OWNER;
    logic                  o_BUSY;
    logic                  o_TIMEOUT;

    modport master (
        input  i_VALID, i_BYTE, i_LAST, i_ACK, i_TX_FULL,
        output o_READY, o_ADDR, o_DATA, o_WE, o_SEL, o_STB, o_CYC, o_OWNER, o_BUSY, o_TIMEOUT
    );

    modport slave (
        output i_VALID, i_BYTE, i_LAST, i_ACK, i_TX_FULL,
        input  o_READY, o_ADDR, o_DATA, o_WE, o_SEL, o_STB, o_CYC, o_OWNER, o_BUSY, o_TIMEOUT
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-locked sharing of the UART TX FIFO write port
module uart_tx_arbiter #(
    parameter int                    N_REQ        = 4,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] UART_TX_ADDR = 'h4,
    parameter int                    TIMEOUT      = 1024
) (
    input logic              i_CLK,
    input logic              i_RST,
    uart_tx_arbiter_if.master bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WRITE, NEXT} state_t;

    state_t                state_q, state_d;
    logic [2:0]            rr_q, rr_d, owner_q, owner_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  last_q, last_d, stb_q, stb_d, busy_q, busy_d, timeout_q, timeout_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            sel_q, sel_d;
    logic [N_REQ-1:0]      ready_q, ready_d;
    logic                  found, launch, own_valid;
    logic [2:0]            pick, cand, lidx, nxt_owner;
    logic [3:0]            sum;

    assign own_valid = |(bus.i_VALID & (N_REQ'(1) << owner_q));
    assign nxt_owner = owner_q == 3'(N_REQ - 1) ? 3'd0 : owner_q + 3'd1;

    // round-robin pick: first valid requester at or above rr_q, wrapping
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum  = {1'b0, rr_q} + 4'(k);
            cand = sum >= 4'(N_REQ) ? 3'(sum - 4'(N_REQ)) : sum[2:0];
            if (!found && |(bus.i_VALID & (N_REQ'(1) << cand))) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // next state and registered outputs; a launch latches a byte and opens a bus write
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        last_d    = last_q;
        data_d    = data_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        stb_d     = stb_q;
        busy_d    = busy_q;
        ready_d   = '0;
        timeout_d = 1'b0;
        launch    = 1'b0;
        lidx      = pick;
        case (state_q)
            IDLE: launch = found && !bus.i_TX_FULL;
            WRITE: begin
                if (bus.i_ACK) begin
                    stb_d   = 1'b0;
                    ready_d = N_REQ'(1) << owner_q;
                    state_d = last_q ? IDLE : NEXT;
                    rr_d    = last_q ? nxt_owner : rr_q;
                    busy_d  = !last_q;
                    cnt_d   = '0;
                end
            end
            NEXT: begin
                lidx = owner_q;
                if (own_valid && !bus.i_TX_FULL) begin
                    launch = 1'b1;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                    rr_d      = nxt_owner;
                    busy_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (launch) begin
            state_d = WRITE;
            owner_d = lidx;
            data_d  = DATA_WIDTH'(8'(bus.i_BYTE >> {lidx, 3'b000}));
            last_d  = |(bus.i_LAST & (N_REQ'(1) << lidx));
            addr_d  = UART_TX_ADDR;
            sel_d   = 4'b0001;
            stb_d   = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = '0;
        end
    end

    // state and output registers with synchronous reset
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            cnt_q     <= '0;
            owner_q   <= '0;
            last_q    <= 1'b0;
            data_q    <= '0;
            addr_q    <= '0;
            sel_q     <= '0;
            stb_q     <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            stb_q     <= stb_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.o_READY   = ready_q;
    assign bus.o_ADDR    = addr_q;
    assign bus.o_DATA    = data_q;
    assign bus.o_WE      = stb_q;
    assign bus.o_SEL     = sel_q;
    assign bus.o_STB     = stb_q;
    assign bus.o_CYC     = stb_q;
    assign bus.o_OWNER   = owner_q;
    assign bus.o_BUSY    = busy_q;
    assign bus.o_TIMEOUT = timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of arbitration order, message locking, full stall, timeout, reset
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ack_en = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();
    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(16)) dut (.i_CLK(clk), .i_RST(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    logic [8:0]  mem [N][16];
    int          head [N] = '{default: 0};
    int          tail [N] = '{default: 0};
    int          rdy  [N] = '{default: 0};
    logic [31:0] log_d [64];
    logic [31:0] log_a [64];
    logic [3:0]  log_s [64];
    logic [2:0]  log_o [64];
    logic        log_w [64];
    int          nlog = 0;

    // one-cycle-latency slave: acknowledges a strobe on the following edge
    always @(posedge clk) bus.i_ACK <= bus.o_STB && !bus.i_ACK && ack_en && !rst;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int r, input logic [7:0] b, input logic l);
        mem[r][tail[r] & 15] = {l, b};
        tail[r]++;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic bit drained();
        for (int i = 0; i < N; i++) if (head[i] != tail[i]) return 1'b0;
        return !bus.o_BUSY && !bus.o_STB;
    endfunction

    task automatic wait_done(input string tag, input int budget);
        int c;
        c = 0;
        do begin
            tick();
            c++;
        end while (!drained() && c < budget);
        check({"done_", tag}, 32'(c < budget), 32'd1);
    endtask

    // requester queues and bus write log, both sampled mid-cycle
    initial begin
        logic [N-1:0]   v;
        logic [8*N-1:0] b;
        logic [N-1:0]   l;
        bus.i_VALID = '0;
        bus.i_BYTE  = '0;
        bus.i_LAST  = '0;
        forever begin
            @(negedge clk);
            if (bus.o_STB && bus.i_ACK && nlog < 64) begin
                log_d[nlog] = bus.o_DATA;
                log_a[nlog] = bus.o_ADDR;
                log_s[nlog] = bus.o_SEL;
                log_o[nlog] = bus.o_OWNER;
                log_w[nlog] = bus.o_WE && bus.o_CYC;
                nlog++;
            end
            for (int i = 0; i < N; i++) begin
                if (bus.o_READY[i]) begin
                    rdy[i]++;
                    head[i]++;
                end
                v[i]        = head[i] < tail[i];
                b[8*i +: 8] = mem[i][head[i] & 15][7:0];
                l[i]        = mem[i][head[i] & 15][8];
            end
            bus.i_VALID = v;
            bus.i_BYTE  = b;
            bus.i_LAST  = l;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int base, n, m, r2;
        logic seen;
        bus.i_TX_FULL = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("rst_stb", 32'(bus.o_STB), 0);
        check("rst_cyc", 32'(bus.o_CYC), 0);
        check("rst_we", 32'(bus.o_WE), 0);
        check("rst_busy", 32'(bus.o_BUSY), 0);
        check("rst_ready", 32'(bus.o_READY), 0);
        check("rst_addr", bus.o_ADDR, 0);
        check("rst_data", bus.o_DATA, 0);
        check("rst_sel", 32'(bus.o_SEL), 0);
        check("rst_owner", 32'(bus.o_OWNER), 0);
        check("rst_tmo", 32'(bus.o_TIMEOUT), 0);

        base = nlog;
        push(1, 8'h48, 1'b0);
        push(1, 8'h69, 1'b1);
        wait_done("t1", 100);
        check("t1_n", 32'(nlog - base), 2);
        check("t1_d0", log_d[base], 32'h48);
        check("t1_d1", log_d[base+1], 32'h69);
        check("t1_addr", log_a[base], 32'h4);
        check("t1_sel", 32'(log_s[base+1]), 32'h1);
        check("t1_we", 32'(log_w[base]), 1);
        check("t1_own", 32'(log_o[base+1]), 1);
        check("t1_rdy", 32'(rdy[1]), 2);
        check("t1_busy", 32'(bus.o_BUSY), 0);

        base = nlog;
        push(0, 8'h01, 1'b1);
        push(3, 8'h03, 1'b1);
        wait_done("rr", 100);
        check("rr_first", 32'(log_o[base]), 3);
        check("rr_second", 32'(log_o[base+1]), 0);
        push(3, 8'h04, 1'b1);
        wait_done("rr3", 100);

        base = nlog;
        for (int k = 0; k < 3; k++) begin
            push(0, 8'(8'hA0 + k), 1'(k == 2));
            push(2, 8'(8'hB0 + k), 1'(k == 2));
        end
        wait_done("t2", 200);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t2_own%0d", k), 32'(log_o[base+k]), k < 3 ? 0 : 2);
            check($sformatf("t2_dat%0d", k), log_d[base+k], k < 3 ? 32'hA0 + 32'(k) : 32'hB0 + 32'(k - 3));
        end
        push(3, 8'h05, 1'b1);
        wait_done("rr0", 100);

        base = nlog;
        for (int mm = 0; mm < 2; mm++)
            for (int i = 0; i < N; i++) push(i, 8'(8'h30 + 16 * mm + i), 1'b1);
        wait_done("t3", 300);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t3_own%0d", k), 32'(log_o[base+k]), 32'(k % 4));
            check($sformatf("t3_dat%0d", k), log_d[base+k], 32'h30 + 32'(16 * (k / 4) + k % 4));
        end

        base = nlog;
        bus.i_TX_FULL = 1'b1;
        push(3, 8'hA5, 1'b1);
        seen = 1'b0;
        repeat (8) begin
            tick();
            seen = seen | bus.o_STB;
        end
        check("t4_hold", 32'(seen), 0);
        bus.i_TX_FULL = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.o_STB && n < 10);
        check("t4_lat", 32'(n <= 2), 1);
        wait_done("t4", 100);
        check("t4_dat", log_d[base], 32'hA5);
        check("t4_own", 32'(log_o[base]), 3);

        base = nlog;
        push(0, 8'h11, 1'b0);
        push(1, 8'h22, 1'b1);
        n = 0;
        while (!bus.o_READY[0] && n < 50) begin
            tick();
            n++;
        end
        check("t5_rdy", 32'(bus.o_READY[0]), 1);
        m = 0;
        while (!bus.o_TIMEOUT && m < 40) begin
            tick();
            m++;
        end
        check("t5_tmo_lat", 32'(m), 16);
        check("t5_tmo_busy", 32'(bus.o_BUSY), 0);
        wait_done("t5", 100);
        check("t5_n", 32'(nlog - base), 2);
        check("t5_own1", 32'(log_o[base+1]), 1);
        check("t5_dat1", log_d[base+1], 32'h22);

        ack_en = 1'b0;
        base = nlog;
        r2 = rdy[2];
        push(2, 8'h77, 1'b1);
        push(0, 8'h55, 1'b1);
        n = 0;
        while (!bus.o_STB && n < 20) begin
            tick();
            n++;
        end
        check("t6_stb", 32'(bus.o_STB), 1);
        check("t6_own", 32'(bus.o_OWNER), 2);
        rst = 1'b1;
        tick();
        check("t6_cyc", 32'(bus.o_CYC), 0);
        check("t6_stb0", 32'(bus.o_STB), 0);
        check("t6_busy", 32'(bus.o_BUSY), 0);
        check("t6_ready", 32'(bus.o_READY), 0);
        tick();
        rst = 1'b0;
        ack_en = 1'b1;
        wait_done("t6", 100);
        check("t6_n", 32'(nlog - base), 2);
        check("t6_first", 32'(log_o[base]), 0);
        check("t6_fdat", log_d[base], 32'h55);
        check("t6_second", 32'(log_o[base+1]), 2);
        check("t6_rdy2", 32'(rdy[2]), 32'(r2 + 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
